// File: rtl/gpio_serial_loader.sv
// gpio_serial_loader: fetches one config word per GPIO, shifts them MSB-first (highest index first)
// through the pad-control daisy chain, then latches the chain or pulses its reset on request.
module gpio_serial_loader #(
    parameter int NUM_IO        = 19,
    parameter int PAD_CTRL_BITS = 13,
    parameter int CLK_DIV       = 4,
    localparam int IDXW         = $clog2(NUM_IO)
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     start,
    input  logic                     clear,
    output logic                     busy,
    output logic                     done,
    output logic [IDXW-1:0]          cfg_idx,
    input  logic [PAD_CTRL_BITS-1:0] cfg_data,
    output logic                     serial_clock,
    output logic                     serial_load,
    output logic                     serial_resetn,
    output logic                     serial_data_out
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int BW = PAD_CTRL_BITS > 1 ? $clog2(PAD_CTRL_BITS) : 1;
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] SH_LO = 3'd2;
    localparam logic [2:0] SH_HI = 3'd3;
    localparam logic [2:0] LD_HI = 3'd4;
    localparam logic [2:0] LD_LO = 3'd5;
    localparam logic [2:0] CLR   = 3'd6;
    localparam logic [2:0] DONE  = 3'd7;

    logic [2:0]               state, state_n;
    logic [DW-1:0]            div_cnt;
    logic [BW-1:0]            bit_cnt, bit_n;
    logic [PAD_CTRL_BITS-1:0] shreg, shreg_n;
    logic [IDXW-1:0]          idx_n;
    logic                     div_end;

    assign div_end = div_cnt == DW'(CLK_DIV - 1);

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        bit_n   = bit_cnt;
        idx_n   = cfg_idx;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = FETCH;
                    idx_n   = IDXW'(NUM_IO - 1);
                end else if (clear) begin
                    state_n = CLR;
                end
            end
            FETCH: begin
                shreg_n = cfg_data;
                bit_n   = BW'(PAD_CTRL_BITS - 1);
                state_n = SH_LO;
            end
            SH_LO: state_n = div_end ? SH_HI : SH_LO;
            SH_HI: begin
                if (div_end) begin
                    if (bit_cnt != '0) begin
                        bit_n   = bit_cnt - BW'(1);
                        shreg_n = shreg << 1;
                        state_n = SH_LO;
                    end else if (cfg_idx != '0) begin
                        idx_n   = cfg_idx - IDXW'(1);
                        state_n = FETCH;
                    end else begin
                        state_n = LD_HI;
                    end
                end
            end
            LD_HI:   state_n = div_end ? LD_LO : LD_HI;
            LD_LO:   state_n = div_end ? DONE : LD_LO;
            CLR:     state_n = div_end ? DONE : CLR;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state           <= IDLE;
            div_cnt         <= '0;
            bit_cnt         <= '0;
            shreg           <= '0;
            cfg_idx         <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            serial_clock    <= 1'b0;
            serial_load     <= 1'b0;
            serial_resetn   <= 1'b0;
            serial_data_out <= 1'b0;
        end else begin
            state           <= state_n;
            div_cnt         <= (state_n != state || div_end) ? '0 : div_cnt + DW'(1);
            bit_cnt         <= bit_n;
            shreg           <= shreg_n;
            cfg_idx         <= idx_n;
            busy            <= state_n != IDLE;
            done            <= state == DONE;
            serial_clock    <= state_n == SH_HI;
            serial_load     <= state_n == LD_HI;
            serial_resetn   <= state_n != CLR;
            if (state_n == SH_LO)
                serial_data_out <= shreg_n[PAD_CTRL_BITS-1];
        end
    end
endmodule
